// File: rtl/scsi_sd_arbiter.sv
// ---------------------------------------------------------------------------
// scsi_sd_arbiter
//
// Shares one host SD block interface between two SCSI target instances
// (ID 0 and ID 1). Each target holds io_rd/io_wr with a block address until
// it sees its io_ack. Targets are granted one at a time, round-robin. The
// host ack and the host buffer write strobe go only to the granted target.
// Requests to an unmounted target get a local one-cycle ack and never reach
// the host.
//
// Ports
//   clk, rst             clock; synchronous active-high reset
//   mounted[1:0]         bit n set = image present for target n
//   tN_lba/rd/wr         target N block address and level-held requests
//   tN_ack               target N io_ack (combinational)
//   tN_buff_din          target N sector-buffer read data
//   tN_buff_wr           host buffer write strobe, gated to target N
//   sd_lba/rd/wr         host block address and requests (registered)
//   sd_ack               host ack, high for the whole sector transfer
//   sd_buff_wr           host buffer write strobe
//   sd_buff_din          buffer data to host, muxed from the owner
//   owner                currently or most recently granted target
//   err[1:0]             sticky per-target host timeout flag
//
// TIMEOUT_CYC: number of REQ cycles to wait for sd_ack; 0 waits forever.
// ---------------------------------------------------------------------------
module scsi_sd_arbiter #(
    parameter int unsigned TIMEOUT_CYC = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  mounted,
    input  logic [31:0] t0_lba,
    input  logic        t0_rd,
    input  logic        t0_wr,
    output logic        t0_ack,
    input  logic [7:0]  t0_buff_din,
    output logic        t0_buff_wr,
    input  logic [31:0] t1_lba,
    input  logic        t1_rd,
    input  logic        t1_wr,
    output logic        t1_ack,
    input  logic [7:0]  t1_buff_din,
    output logic        t1_buff_wr,
    output logic [31:0] sd_lba,
    output logic        sd_rd,
    output logic        sd_wr,
    input  logic        sd_ack,
    input  logic        sd_buff_wr,
    output logic [7:0]  sd_buff_din,
    output logic        owner,
    output logic [1:0]  err
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        XFER = 3'd2,
        FAKE = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic        TMO_EN   = (TIMEOUT_CYC != 32'd0);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC) - 32'd1;

    state_t      state_r, state_s;
    logic        owner_r, owner_s;
    logic        last_r,  last_s;
    logic        sd_rd_r, sd_rd_s;
    logic        sd_wr_r, sd_wr_s;
    logic [31:0] sd_lba_r, sd_lba_s;
    logic [1:0]  err_r,   err_s;
    logic [31:0] tmo_cnt_r, tmo_cnt_s;

    logic        pend0_s, pend1_s;
    logic        sel_s;
    logic        sel_rd_s;
    logic        active_s;
    logic        fake_s;
    logic        xfer_s;

    // State and datapath registers; reset leaves last=1 so target 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            owner_r   <= 1'b0;
            last_r    <= 1'b1;
            sd_rd_r   <= 1'b0;
            sd_wr_r   <= 1'b0;
            sd_lba_r  <= 32'd0;
            err_r     <= 2'b00;
            tmo_cnt_r <= 32'd0;
        end else begin
            state_r   <= state_s;
            owner_r   <= owner_s;
            last_r    <= last_s;
            sd_rd_r   <= sd_rd_s;
            sd_wr_r   <= sd_wr_s;
            sd_lba_r  <= sd_lba_s;
            err_r     <= err_s;
            tmo_cnt_r <= tmo_cnt_s;
        end
    end

    // Arbitration, next-state and next-register values.
    always_comb begin
        state_s   = state_r;
        owner_s   = owner_r;
        last_s    = last_r;
        sd_rd_s   = sd_rd_r;
        sd_wr_s   = sd_wr_r;
        sd_lba_s  = sd_lba_r;
        err_s     = err_r;
        tmo_cnt_s = 32'd0;

        pend0_s  = t0_rd | t0_wr;
        pend1_s  = t1_rd | t1_wr;
        // On a tie the target that was not served last wins; otherwise the
        // only pending one (pend1 alone selects 1, pend0 alone selects 0).
        if (pend0_s && pend1_s) begin
            sel_s = ~last_r;
        end else begin
            sel_s = pend1_s;
        end
        // Read takes priority when a target raises both; the write stays pending.
        if (sel_s) begin
            sel_rd_s = t1_rd;
        end else begin
            sel_rd_s = t0_rd;
        end

        case (state_r)
            IDLE: begin
                if (pend0_s || pend1_s) begin
                    owner_s  = sel_s;
                    last_s   = sel_s;
                    sd_lba_s = sel_s ? t1_lba : t0_lba;
                    if (mounted[sel_s]) begin
                        state_s = REQ;
                        sd_rd_s = sel_rd_s;
                        sd_wr_s = ~sel_rd_s;
                    end else begin
                        state_s = FAKE;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (sd_ack) begin
                    sd_rd_s = 1'b0;
                    sd_wr_s = 1'b0;
                    state_s = XFER;
                end else if (TMO_EN && (tmo_cnt_r == TMO_LAST)) begin
                    // Host never answered: release it and complete locally.
                    sd_rd_s = 1'b0;
                    sd_wr_s = 1'b0;
                    err_s   = err_r | (owner_r ? 2'b10 : 2'b01);
                    state_s = FAKE;
                end else if (TMO_EN) begin
                    tmo_cnt_s = tmo_cnt_r + 32'd1;
                end else begin
                    tmo_cnt_s = 32'd0;
                end
            end
            XFER: begin
                if (!sd_ack) begin
                    state_s = DONE;
                end else begin
                    state_s = XFER;
                end
            end
            FAKE: begin
                state_s = DONE;
            end
            DONE: begin
                // One dead cycle lets the served target drop its request.
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
                sd_rd_s = 1'b0;
                sd_wr_s = 1'b0;
            end
        endcase
    end

    // Ack and buffer-strobe routing to the owner only.
    always_comb begin
        active_s   = (state_r == REQ) || (state_r == XFER);
        fake_s     = (state_r == FAKE);
        xfer_s     = (state_r == XFER);
        t0_ack     = ~owner_r & ((sd_ack & active_s) | fake_s);
        t1_ack     =  owner_r & ((sd_ack & active_s) | fake_s);
        t0_buff_wr = ~owner_r & sd_buff_wr & xfer_s;
        t1_buff_wr =  owner_r & sd_buff_wr & xfer_s;
    end

    // Owner is frozen from grant to IDLE, so this mux is stable for a sector.
    always_comb begin
        if (owner_r) begin
            sd_buff_din = t1_buff_din;
        end else begin
            sd_buff_din = t0_buff_din;
        end
    end

    assign sd_lba = sd_lba_r;
    assign sd_rd  = sd_rd_r;
    assign sd_wr  = sd_wr_r;
    assign owner  = owner_r;
    assign err    = err_r;

endmodule
